mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Shares one physical memory port between the instruction-cache miss path (imem side) and the data-cache miss/writeback path (dmem side) of the LC-3b pipeline. It grants one requester at a time and latches the request into a registered pmem transaction. It holds the transaction until pmem_resp, then routes the response back to the owner. Data side has priority, with a streak limit so fetch is never starved.

Parameters:
LINE_W, 128, width of one memory line (rdata/wdata) in bits
ADDR_W, 16, address width (matches lc3b_word)
MAX_D_STREAK, 4, max consecutive dmem grants while imem is waiting before imem must be granted (1..15)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
imem_read  input  1  I-side line read request, held until imem_resp
imem_address  input  ADDR_W  I-side line address
imem_resp  output  1  one-cycle pulse: I-side transaction done, imem_rdata valid
imem_rdata  output  LINE_W  I-side read data
dmem_read  input  1  D-side line read request, held until dmem_resp
dmem_write  input  1  D-side line write request, held until dmem_resp
dmem_address  input  ADDR_W  D-side line address
dmem_wdata  input  LINE_W  D-side write data
dmem_resp  output  1  one-cycle pulse: D-side transaction done
dmem_rdata  output  LINE_W  D-side read data
pmem_read  output  1  registered read strobe to physical memory
pmem_write  output  1  registered write strobe to physical memory
pmem_address  output  ADDR_W  registered address
pmem_wdata  output  LINE_W  registered write data
pmem_rdata  input  LINE_W  physical memory read data
pmem_resp  input  1  physical memory done, one cycle
arb_busy  output  1  high in any state other than IDLE

Behaviour:
- States: IDLE, SERVE_I, SERVE_D, RELEASE.
- Reset (async, rst_n=0) and IDLE outputs:
  - state=IDLE, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0.
  - imem_resp=0, dmem_resp=0, d_streak=0, arb_busy=0.
- IDLE, arbitration, decided on the clock edge:
  - D pending = dmem_read|dmem_write; I pending = imem_read.
  - Only one pending: grant it.
  - Both pending: grant I if d_streak>=MAX_D_STREAK, else grant D.
  - On grant, register the owner's address (and wdata for D) into pmem_address/pmem_wdata. Assert pmem_read or pmem_write from the next cycle. Enter SERVE_I or SERVE_D.
  - Grant to D with I pending: d_streak+=1, saturating at 15.
  - Grant to I, or grant to D with I idle: d_streak=0.
- dmem_read and dmem_write both high is illegal; write wins (pmem_write=1, pmem_read=0).
- SERVE_x:
  - pmem strobes, address and wdata are held constant. Requester inputs are ignored after grant.
  - When pmem_resp=1, the owner's resp is asserted combinationally in the same cycle. Owner rdata = pmem_rdata in that cycle; the non-owner resp stays 0.
  - Next state is RELEASE, with strobes cleared at that edge.
- Latency: request seen in IDLE at edge N → pmem strobe high from N+1 → resp the cycle pmem_resp arrives. Minimum 2 cycles with a zero-wait pmem.
- RELEASE: one mandatory bubble cycle with no strobes and no resp, so the owner can drop its request. Then IDLE. Back-to-back grants are therefore at least 1 cycle apart.
- imem_rdata/dmem_rdata hold their last value when resp=0. Only the resp signals qualify them.
- pmem_resp outside SERVE_x is ignored; no resp is generated.
- A requester deasserting before resp is illegal. The transaction still completes and the resp pulse is still issued.
- Reset mid-transaction: everything returns to IDLE immediately and strobes drop asynchronously. An in-flight pmem_resp after reset is ignored.

Test Plan:
- Reset: rst_n=0 mid-SERVE_D with pmem_write=1 → pmem_write falls without waiting for clk; state=IDLE, d_streak=0 after release.
- Single I read: imem_read=1, addr=0x3000, pmem_resp 3 cycles after strobe with rdata=0xA5…A5 → pmem_read=1, pmem_address=0x3000, imem_resp pulses once with that data, dmem_resp=0.
- Simultaneous: imem_read and dmem_write (addr 0x4010, wdata 0x1234…) in the same cycle → D served first (pmem_write=1, addr 0x4010), then RELEASE, then I served.
- Starvation: dmem_read continuously re-asserted, imem_read held, MAX_D_STREAK=4 → exactly 4 D grants, then an I grant; d_streak resets to 0.
- Illegal dual D: dmem_read=dmem_write=1 → pmem_write=1, pmem_read=0; a single dmem_resp.
- Stray pmem_resp in IDLE/RELEASE → no imem_resp/dmem_resp, state unchanged; inputs changed during SERVE do not alter pmem_address.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the I/D miss paths, the arbiter and the physical memory port.
// slave = arbiter view, master = view of the surrounding requesters and memory.
interface mem_arbiter_if #(
    parameter int LINE_W = 128,
    parameter int ADDR_W = 16
);
    logic              imem_read;
    logic [ADDR_W-1:0] imem_address;
    logic              imem_resp;
    logic [LINE_W-1:0] imem_rdata;

    logic              dmem_read;
    logic              dmem_write;
    logic [ADDR_W-1:0] dmem_address;
    logic [LINE_W-1:0] dmem_wdata;
    logic              dmem_resp;
    logic [LINE_W-1:0] dmem_rdata;

    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport slave (
        input  imem_read, imem_address,
        input  dmem_read, dmem_write, dmem_address, dmem_wdata,
        input  pmem_rdata, pmem_resp,
        output imem_resp, imem_rdata, dmem_resp, dmem_rdata,
        output pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport master (
        output imem_read, imem_address,
        output dmem_read, dmem_write, dmem_address, dmem_wdata,
        output pmem_rdata, pmem_resp,
        input  imem_resp, imem_rdata, dmem_resp, dmem_rdata,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single physical memory port: data side has priority,
// bounded by a streak limit so instruction fetch cannot starve.
//
// state   | meaning
// IDLE    | no transaction, arbitrate pending requests on the next edge
// SERVE_I | pmem transaction owned by the I side, waiting for pmem_resp
// SERVE_D | pmem transaction owned by the D side, waiting for pmem_resp
// RELEASE | one bubble cycle so the owner can drop its request
module mem_arbiter #(
    parameter int LINE_W       = 128,
    parameter int ADDR_W       = 16,
    parameter int MAX_D_STREAK = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_arbiter_if.slave   bus,
    output logic           arb_busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [3:0] STREAK_LIMIT = 4'(MAX_D_STREAK);

    state_t            state_q, state_d;
    logic              pmem_read_q, pmem_read_d;
    logic              pmem_write_q, pmem_write_d;
    logic [ADDR_W-1:0] pmem_address_q, pmem_address_d;
    logic [LINE_W-1:0] pmem_wdata_q, pmem_wdata_d;
    logic [3:0]        d_streak_q, d_streak_d;
    logic [LINE_W-1:0] imem_rdata_q, imem_rdata_d;
    logic [LINE_W-1:0] dmem_rdata_q, dmem_rdata_d;

    logic d_pend, i_pend, grant_d, grant_i;
    logic imem_resp_c, dmem_resp_c;

    assign d_pend  = bus.dmem_read | bus.dmem_write;
    assign i_pend  = bus.imem_read;
    assign grant_d = d_pend && (!i_pend || (d_streak_q < STREAK_LIMIT));
    assign grant_i = i_pend && !grant_d;

    // Responses are combinational so the owner sees data in the pmem_resp cycle.
    assign imem_resp_c = (state_q == SERVE_I) && bus.pmem_resp;
    assign dmem_resp_c = (state_q == SERVE_D) && bus.pmem_resp;

    always_comb begin
        state_d        = state_q;
        pmem_read_d    = pmem_read_q;
        pmem_write_d   = pmem_write_q;
        pmem_address_d = pmem_address_q;
        pmem_wdata_d   = pmem_wdata_q;
        d_streak_d     = d_streak_q;
        imem_rdata_d   = imem_resp_c ? bus.pmem_rdata : imem_rdata_q;
        dmem_rdata_d   = dmem_resp_c ? bus.pmem_rdata : dmem_rdata_q;

        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d        = SERVE_D;
                    pmem_address_d = bus.dmem_address;
                    pmem_wdata_d   = bus.dmem_wdata;
                    // A simultaneous read+write is illegal; the write takes the port.
                    pmem_write_d   = bus.dmem_write;
                    pmem_read_d    = ~bus.dmem_write;
                    if (i_pend)
                        d_streak_d = (d_streak_q == 4'hF) ? 4'hF : d_streak_q + 4'd1;
                    else
                        d_streak_d = 4'd0;
                end else if (grant_i) begin
                    state_d        = SERVE_I;
                    pmem_address_d = bus.imem_address;
                    pmem_read_d    = 1'b1;
                    pmem_write_d   = 1'b0;
                    d_streak_d     = 4'd0;
                end
            end
            SERVE_I, SERVE_D: begin
                if (bus.pmem_resp) begin
                    state_d      = RELEASE;
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= '0;
            pmem_wdata_q   <= '0;
            d_streak_q     <= 4'd0;
            imem_rdata_q   <= '0;
            dmem_rdata_q   <= '0;
        end else begin
            state_q        <= state_d;
            pmem_read_q    <= pmem_read_d;
            pmem_write_q   <= pmem_write_d;
            pmem_address_q <= pmem_address_d;
            pmem_wdata_q   <= pmem_wdata_d;
            d_streak_q     <= d_streak_d;
            imem_rdata_q   <= imem_rdata_d;
            dmem_rdata_q   <= dmem_rdata_d;
        end
    end

    assign bus.pmem_read    = pmem_read_q;
    assign bus.pmem_write   = pmem_write_q;
    assign bus.pmem_address = pmem_address_q;
    assign bus.pmem_wdata   = pmem_wdata_q;
    assign bus.imem_resp    = imem_resp_c;
    assign bus.dmem_resp    = dmem_resp_c;
    assign bus.imem_rdata   = imem_resp_c ? bus.pmem_rdata : imem_rdata_q;
    assign bus.dmem_rdata   = dmem_resp_c ? bus.pmem_rdata : dmem_rdata_q;
    assign arb_busy         = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change and outputs are sampled on the falling edge.
module tb_mem_arbiter;

    localparam int LINE_W = 128;
    localparam int ADDR_W = 16;

    logic clk;
    logic rst_n;
    logic arb_busy;
    int   checks;
    int   errors;
    int   i_resp_cnt;
    int   d_resp_cnt;

    localparam logic [LINE_W-1:0] DATA_A5 = {16{8'hA5}};
    localparam logic [LINE_W-1:0] DATA_5A = {16{8'h5A}};
    localparam logic [LINE_W-1:0] WDATA_1 = {8{16'h1234}};
    localparam logic [LINE_W-1:0] WDATA_2 = {4{32'hDEADBEEF}};
    localparam logic [LINE_W-1:0] DATA_C3 = {16{8'hC3}};

    mem_arbiter_if #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) bus ();

    mem_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .MAX_D_STREAK(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .arb_busy (arb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        i_resp_cnt = 0;
        d_resp_cnt = 0;
    end
    always @(posedge clk) begin
        if (bus.imem_resp) i_resp_cnt <= i_resp_cnt + 1;
        if (bus.dmem_resp) d_resp_cnt <= d_resp_cnt + 1;
    end

    task automatic drop_all();
        bus.imem_read  = 1'b0;
        bus.dmem_read  = 1'b0;
        bus.dmem_write = 1'b0;
    endtask

    // Assumes a transaction is in SERVE at a falling edge; ends in IDLE at a falling edge.
    task automatic finish_txn(input logic [LINE_W-1:0] rd);
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = rd;
        @(negedge clk);
        bus.pmem_resp = 1'b0;
        drop_all();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drop_all();
        bus.imem_address = '0;
        bus.dmem_address = '0;
        bus.dmem_wdata   = '0;
        bus.pmem_rdata   = '0;
        bus.pmem_resp    = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.pmem_read, bus.pmem_write, bus.imem_resp, bus.dmem_resp, arb_busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b expected 00000",
                     {bus.pmem_read, bus.pmem_write, bus.imem_resp, bus.dmem_resp, arb_busy});
        end
        checks++;
        if (bus.pmem_address !== 16'h0 || bus.pmem_wdata !== '0 || dut.d_streak_q !== 4'd0) begin
            errors++;
            $display("FAIL reset_regs: addr %h wdata %h streak %0d expected zeros",
                     bus.pmem_address, bus.pmem_wdata, dut.d_streak_q);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_i();
        int i0;
        int d0;
        i0 = i_resp_cnt;
        d0 = d_resp_cnt;
        bus.imem_read    = 1'b1;
        bus.imem_address = 16'h3000;
        @(negedge clk);
        checks++;
        if (bus.pmem_read !== 1'b1 || bus.pmem_write !== 1'b0 || bus.pmem_address !== 16'h3000) begin
            errors++;
            $display("FAIL single_i_grant: rd %b wr %b addr %h expected 1 0 3000",
                     bus.pmem_read, bus.pmem_write, bus.pmem_address);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.imem_resp !== 1'b0 || bus.pmem_read !== 1'b1) begin
            errors++;
            $display("FAIL single_i_wait: resp %b rd %b expected 0 1", bus.imem_resp, bus.pmem_read);
        end
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = DATA_A5;
        #1;
        checks++;
        if (bus.imem_resp !== 1'b1 || bus.dmem_resp !== 1'b0 || bus.imem_rdata !== DATA_A5) begin
            errors++;
            $display("FAIL single_i_resp: iresp %b dresp %b data %h expected 1 0 %h",
                     bus.imem_resp, bus.dmem_resp, bus.imem_rdata, DATA_A5);
        end
        @(negedge clk);
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = DATA_5A;
        drop_all();
        #1;
        checks++;
        if (bus.imem_resp !== 1'b0 || bus.pmem_read !== 1'b0 || arb_busy !== 1'b1
            || bus.imem_rdata !== DATA_A5) begin
            errors++;
            $display("FAIL single_i_release: resp %b rd %b busy %b data %h expected 0 0 1 %h",
                     bus.imem_resp, bus.pmem_read, arb_busy, bus.imem_rdata, DATA_A5);
        end
        @(negedge clk);
        checks++;
        if (arb_busy !== 1'b0 || i_resp_cnt - i0 !== 1 || d_resp_cnt - d0 !== 0) begin
            errors++;
            $display("FAIL single_i_pulses: busy %b ipulses %0d dpulses %0d expected 0 1 0",
                     arb_busy, i_resp_cnt - i0, d_resp_cnt - d0);
        end
    endtask

    task automatic test_simultaneous();
        bus.imem_read    = 1'b1;
        bus.imem_address = 16'h3000;
        bus.dmem_write   = 1'b1;
        bus.dmem_address = 16'h4010;
        bus.dmem_wdata   = WDATA_1;
        @(negedge clk);
        checks++;
        if (bus.pmem_write !== 1'b1 || bus.pmem_read !== 1'b0 || bus.pmem_address !== 16'h4010
            || bus.pmem_wdata !== WDATA_1 || dut.d_streak_q !== 4'd1) begin
            errors++;
            $display("FAIL simul_d_first: wr %b rd %b addr %h wdata %h streak %0d expected 1 0 4010 %h 1",
                     bus.pmem_write, bus.pmem_read, bus.pmem_address, bus.pmem_wdata,
                     dut.d_streak_q, WDATA_1);
        end
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = DATA_C3;
        #1;
        checks++;
        if (bus.dmem_resp !== 1'b1 || bus.imem_resp !== 1'b0 || bus.dmem_rdata !== DATA_C3) begin
            errors++;
            $display("FAIL simul_d_resp: dresp %b iresp %b ddata %h expected 1 0 %h",
                     bus.dmem_resp, bus.imem_resp, bus.dmem_rdata, DATA_C3);
        end
        @(negedge clk);
        bus.pmem_resp  = 1'b0;
        bus.dmem_write = 1'b0;
        checks++;
        if (bus.pmem_write !== 1'b0 || bus.pmem_read !== 1'b0 || arb_busy !== 1'b1) begin
            errors++;
            $display("FAIL simul_release: wr %b rd %b busy %b expected 0 0 1",
                     bus.pmem_write, bus.pmem_read, arb_busy);
        end
        @(negedge clk);
        checks++;
        if (arb_busy !== 1'b0 || bus.pmem_read !== 1'b0) begin
            errors++;
            $display("FAIL simul_idle_gap: busy %b rd %b expected 0 0", arb_busy, bus.pmem_read);
        end
        @(negedge clk);
        checks++;
        if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 16'h3000 || dut.d_streak_q !== 4'd0) begin
            errors++;
            $display("FAIL simul_i_second: rd %b addr %h streak %0d expected 1 3000 0",
                     bus.pmem_read, bus.pmem_address, dut.d_streak_q);
        end
        finish_txn(DATA_A5);
    endtask

    task automatic test_starvation();
        logic [ADDR_W-1:0] exp_addr;
        logic [3:0]        exp_streak;
        logic              exp_rd;
        bus.imem_read    = 1'b1;
        bus.imem_address = 16'h3000;
        for (int g = 0; g < 5; g++) begin
            bus.dmem_read    = 1'b1;
            bus.dmem_address = 16'h5000 + 16'(g);
            @(negedge clk);
            exp_rd     = 1'b1;
            exp_addr   = (g < 4) ? 16'h5000 + 16'(g) : 16'h3000;
            exp_streak = (g < 4) ? 4'(g + 1) : 4'd0;
            checks++;
            if (bus.pmem_read !== exp_rd || bus.pmem_address !== exp_addr
                || dut.d_streak_q !== exp_streak || bus.pmem_write !== 1'b0) begin
                errors++;
                $display("FAIL starve_grant%0d: rd %b addr %h streak %0d expected 1 %h %0d",
                         g, bus.pmem_read, bus.pmem_address, dut.d_streak_q, exp_addr, exp_streak);
            end
            bus.pmem_resp  = 1'b1;
            bus.pmem_rdata = DATA_5A;
            #1;
            checks++;
            if (bus.dmem_resp !== (g < 4) || bus.imem_resp !== (g == 4)) begin
                errors++;
                $display("FAIL starve_owner%0d: dresp %b iresp %b expected %b %b",
                         g, bus.dmem_resp, bus.imem_resp, g < 4, g == 4);
            end
            @(negedge clk);
            bus.pmem_resp = 1'b0;
            bus.dmem_read = 1'b0;
            if (g == 4) bus.imem_read = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_dual_d();
        int d0;
        d0 = d_resp_cnt;
        bus.dmem_read    = 1'b1;
        bus.dmem_write   = 1'b1;
        bus.dmem_address = 16'h6000;
        bus.dmem_wdata   = WDATA_2;
        @(negedge clk);
        checks++;
        if (bus.pmem_write !== 1'b1 || bus.pmem_read !== 1'b0 || bus.pmem_wdata !== WDATA_2) begin
            errors++;
            $display("FAIL dual_d_strobe: wr %b rd %b wdata %h expected 1 0 %h",
                     bus.pmem_write, bus.pmem_read, bus.pmem_wdata, WDATA_2);
        end
        finish_txn(DATA_C3);
        checks++;
        if (d_resp_cnt - d0 !== 1 || dut.d_streak_q !== 4'd0) begin
            errors++;
            $display("FAIL dual_d_resp: dpulses %0d streak %0d expected 1 0",
                     d_resp_cnt - d0, dut.d_streak_q);
        end
    endtask

    task automatic test_stray_and_hold();
        bus.pmem_resp = 1'b1;
        #1;
        checks++;
        if (bus.imem_resp !== 1'b0 || bus.dmem_resp !== 1'b0) begin
            errors++;
            $display("FAIL stray_idle_resp: iresp %b dresp %b expected 0 0", bus.imem_resp, bus.dmem_resp);
        end
        @(negedge clk);
        bus.pmem_resp = 1'b0;
        checks++;
        if (arb_busy !== 1'b0 || bus.pmem_read !== 1'b0) begin
            errors++;
            $display("FAIL stray_idle_state: busy %b rd %b expected 0 0", arb_busy, bus.pmem_read);
        end
        bus.imem_read    = 1'b1;
        bus.imem_address = 16'h7000;
        @(negedge clk);
        bus.imem_address = 16'h7777;
        bus.dmem_write   = 1'b1;
        bus.dmem_address = 16'h8888;
        @(negedge clk);
        checks++;
        if (bus.pmem_address !== 16'h7000 || bus.pmem_write !== 1'b0 || bus.pmem_read !== 1'b1) begin
            errors++;
            $display("FAIL serve_hold: addr %h wr %b rd %b expected 7000 0 1",
                     bus.pmem_address, bus.pmem_write, bus.pmem_read);
        end
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = DATA_A5;
        @(negedge clk);
        drop_all();
        #1;
        checks++;
        if (bus.imem_resp !== 1'b0 || bus.dmem_resp !== 1'b0 || arb_busy !== 1'b1) begin
            errors++;
            $display("FAIL stray_release: iresp %b dresp %b busy %b expected 0 0 1",
                     bus.imem_resp, bus.dmem_resp, arb_busy);
        end
        @(negedge clk);
        bus.pmem_resp = 1'b0;
        checks++;
        if (arb_busy !== 1'b0 || bus.pmem_write !== 1'b0) begin
            errors++;
            $display("FAIL stray_back_idle: busy %b wr %b expected 0 0", arb_busy, bus.pmem_write);
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        bus.dmem_write   = 1'b1;
        bus.dmem_address = 16'h9000;
        bus.dmem_wdata   = WDATA_1;
        @(negedge clk);
        checks++;
        if (bus.pmem_write !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre: wr %b expected 1", bus.pmem_write);
        end
        #2;
        rst_n         = 1'b0;
        bus.pmem_resp = 1'b1;
        #1;
        checks++;
        if (bus.pmem_write !== 1'b0 || arb_busy !== 1'b0 || bus.dmem_resp !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_async: wr %b busy %b dresp %b expected 0 0 0",
                     bus.pmem_write, arb_busy, bus.dmem_resp);
        end
        @(negedge clk);
        d0 = d_resp_cnt;
        drop_all();
        rst_n = 1'b1;
        @(negedge clk);
        bus.pmem_resp = 1'b0;
        checks++;
        if (arb_busy !== 1'b0 || dut.d_streak_q !== 4'd0 || d_resp_cnt - d0 !== 0) begin
            errors++;
            $display("FAIL rst_mid_after: busy %b streak %0d dpulses %0d expected 0 0 0",
                     arb_busy, dut.d_streak_q, d_resp_cnt - d0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        @(negedge clk);
        test_reset();
        test_single_i();
        test_simultaneous();
        test_starvation();
        test_dual_d();
        test_stray_and_hold();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
